cordic_stream_ctrl: RTL

//  Initiator-side sequencer for the pipelined cosine CORDIC unit (cordic).

---
 rtl/cordic_stream_ctrl_if.sv | 43 ++++
 rtl/cordic_stream_ctrl.sv | 89 ++++++++
 2 files changed

// File: rtl/cordic_stream_ctrl_if.sv
// Stream-side bundle for cordic_stream_ctrl: operand input, pipeline issue/return, result output, status.
// Optional tag signals exist only when CORDIC_STREAM_TAG_EN is defined.
interface cordic_stream_ctrl_if #(
    parameter int DW         = 32,
    parameter int FIFO_DEPTH = 32
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          clk_en;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          pipe_clk_en;
    logic [DW-1:0] pipe_dataa;
    logic [DW-1:0] pipe_result;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] inflight;
    logic          busy;
`ifdef CORDIC_STREAM_TAG_EN
    logic [7:0]    in_tag;
    logic [7:0]    out_tag;

    modport slave (
        input  clk_en, in_valid, in_data, pipe_result, out_ready, in_tag,
        output in_ready, pipe_clk_en, pipe_dataa, out_valid, out_data, inflight, busy, out_tag
    );
    modport master (
        output clk_en, in_valid, in_data, pipe_result, out_ready, in_tag,
        input  in_ready, pipe_clk_en, pipe_dataa, out_valid, out_data, inflight, busy, out_tag
    );
`else
    modport slave (
        input  clk_en, in_valid, in_data, pipe_result, out_ready,
        output in_ready, pipe_clk_en, pipe_dataa, out_valid, out_data, inflight, busy
    );
    modport master (
        output clk_en, in_valid, in_data, pipe_result, out_ready,
        input  in_ready, pipe_clk_en, pipe_dataa, out_valid, out_data, inflight, busy
    );
`endif
endinterface

// File: rtl/cordic_stream_ctrl.sv
// Credit-based issue sequencer for a fixed-latency cosine CORDIC pipeline with an in-order FWFT result FIFO.
// Define CORDIC_STREAM_TAG_EN to carry an 8-bit tag alongside each operand/result.
module cordic_stream_ctrl #(
    parameter int LATENCY    = 16,
    parameter int FIFO_DEPTH = 32,
    parameter int DW         = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    cordic_stream_ctrl_if.slave  bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [LATENCY-1:0] vld_sr_q, vld_sr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [CW-1:0]      inflight_q, inflight_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [DW-1:0]      mem_q [FIFO_DEPTH];

    logic en, credit, in_ready_w, accept, push, pop, out_valid_w;

    assign en          = bus.clk_en;
    // A pop on the same edge returns no credit: occupancy is judged on registered state only.
    assign credit      = ({1'b0, count_q} + {1'b0, inflight_q}) < (CW+1)'(FIFO_DEPTH);
    assign in_ready_w  = en & ~reset & credit;
    assign accept      = bus.in_valid & in_ready_w;
    assign push        = en & vld_sr_q[LATENCY-1];
    assign out_valid_w = (count_q != '0);
    assign pop         = en & bus.out_ready & out_valid_w;

    always_comb begin
        vld_sr_d   = {vld_sr_q[LATENCY-2:0], accept};
        inflight_d = inflight_q + CW'(accept) - CW'(push);
        count_d    = count_q + CW'(push) - CW'(pop);
        wr_ptr_d   = wr_ptr_q + AW'(push);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_sr_q   <= '0;
            inflight_q <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else if (en) begin
            vld_sr_q   <= vld_sr_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
        if (!reset && push && !pop)
            assert (count_q < CW'(FIFO_DEPTH));
    end

    always_ff @(posedge clock) begin
        if (push)
            mem_q[wr_ptr_q] <= bus.pipe_result;
    end

    assign bus.in_ready    = in_ready_w;
    assign bus.pipe_clk_en = en & ~reset;
    assign bus.pipe_dataa  = accept ? bus.in_data : '0;
    assign bus.out_valid   = out_valid_w;
    assign bus.out_data    = out_valid_w ? mem_q[rd_ptr_q] : '0;
    assign bus.inflight    = inflight_q;
    assign bus.busy        = (inflight_q != '0) | out_valid_w;

`ifdef CORDIC_STREAM_TAG_EN
    logic [7:0] tag_sr_q  [LATENCY];
    logic [7:0] tag_mem_q [FIFO_DEPTH];

    // Tag delay line mirrors vld_sr so the tag is aligned with pipe_result at push time.
    always_ff @(posedge clock) begin
        if (en) begin
            tag_sr_q[0] <= bus.in_tag;
            for (int i = 1; i < LATENCY; i++)
                tag_sr_q[i] <= tag_sr_q[i-1];
        end
        if (push)
            tag_mem_q[wr_ptr_q] <= tag_sr_q[LATENCY-1];
    end

    assign bus.out_tag = out_valid_w ? tag_mem_q[rd_ptr_q] : 8'd0;
`endif
endmodule
